// File: rtl/spw_sw_pkg.sv
// Shared switch-matrix definitions: word-format constants, column reader
// state encoding and the packet terminator test.
package spw_sw_pkg;

  localparam int         CTRL_BIT = 8;
  localparam logic [7:0] EOP_CODE = 8'h00;
  localparam logic [7:0] EEP_CODE = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    EEPW
  } rdState_t;

  // A word ends a packet when it is a control word carrying EOP or EEP.
  function automatic logic is_term(input logic ctrlFlag, input logic [7:0] code);
    return ctrlFlag && ((code == EOP_CODE) || (code == EEP_CODE));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting line at or
// after ptr, wrapping past the top line back to line 0.
module rr_arbiter #(
  parameter int PORTNUM = 16,
  parameter int AW      = 4
) (
  input  logic [PORTNUM-1:0] req,
  input  logic [AW-1:0]      ptr,
  output logic [PORTNUM-1:0] grant,
  output logic [AW-1:0]      grantIdx,
  output logic               anyReq
);

  int idx;

  // Scan lines in priority order starting at ptr; the first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    grant    = '0;
    grantIdx = '0;
    anyReq   = 1'b0;
    idx      = 0;
    for (int i = 0; i < PORTNUM; i++) begin
      idx = int'(ptr) + i;
      if (idx >= PORTNUM) idx = idx - PORTNUM;
      if (!anyReq && req[idx]) begin
        anyReq        = 1'b1;
        grant[idx]    = 1'b1;
        grantIdx      = AW'(idx);
      end
    end
  end

endmodule

// File: rtl/column_reader.sv
// Output-side reader for one switch-matrix column. Grants one input line
// round-robin, streams its packet into the Tx FIFO until EOP/EEP, and closes
// a stalled packet with an inserted EEP after TMO empty cycles.
module column_reader
  import spw_sw_pkg::*;
#(
  parameter int BW      = 10,
  parameter int PORTNUM = 16,
  parameter int AW      = 4,
  parameter int TMO     = 1023,
  parameter int TW      = 10
) (
  input  logic                  gclk,
  input  logic                  reset,
  input  logic [PORTNUM-1:0]    cell_empty_i,
  input  logic [PORTNUM*BW-1:0] cell_data_i,
  output logic [PORTNUM-1:0]    cell_rd_o,
  input  logic                  tx_afull_i,
  output logic                  tx_wr_o,
  output logic [BW-1:0]         tx_data_o,
  output logic [AW-1:0]         sel_line_o,
  output logic                  busy_o,
  output logic                  pkt_done_o,
  output logic                  tmo_o
);

  localparam logic [BW-1:0] EEP_WORD = BW'({1'b1, EEP_CODE});
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  rdState_t           curState, nextState;
  logic [AW-1:0]      rrPtr, grantIdx, nextPtr;
  logic [PORTNUM-1:0] grantVec, selOneHot;
  logic               anyReq, takeGrant, popNow, eepNow, termPop, selEmpty;
  logic [BW-1:0]      headWord;
  logic [TW-1:0]      tmoCnt;

  rr_arbiter #(.PORTNUM(PORTNUM), .AW(AW)) u_arb (
    .req      (~cell_empty_i),
    .ptr      (rrPtr),
    .grant    (grantVec),
    .grantIdx (grantIdx),
    .anyReq   (anyReq)
  );

  // Head word of the granted line, taken straight from its fall-through cell.
  always_comb begin
    headWord = '0;
    for (int k = 0; k < PORTNUM; k++) begin
      if (k == int'(sel_line_o)) headWord = cell_data_i[k*BW +: BW];
    end
  end

  assign selEmpty = cell_empty_i[sel_line_o];
  assign termPop  = popNow && is_term(headWord[CTRL_BIT], headWord[7:0]);
  assign nextPtr  = (sel_line_o == AW'(PORTNUM - 1)) ? '0 : sel_line_o + AW'(1);
  assign busy_o   = (curState != IDLE);
  // NOTE: the pop strobe is combinational, so it is masked during reset;
  // otherwise a word would be consumed from the cell and then dropped.
  assign cell_rd_o = (popNow && !reset) ? selOneHot : '0;

  // State register.
  always_ff @(posedge gclk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) curState <= IDLE;
    else       curState <= nextState;
  end

  // Next-state and per-cycle actions: grant in IDLE, pop in XFER, EEP in EEPW.
  always_comb begin
    nextState = curState;
    takeGrant = 1'b0;
    popNow    = 1'b0;
    eepNow    = 1'b0;
    case (curState)
      IDLE: begin
        if (anyReq) begin
          takeGrant = 1'b1;
          nextState = XFER;
        end
      end
      XFER: begin
        if (!selEmpty && !tx_afull_i) begin
          popNow = 1'b1;
          if (is_term(headWord[CTRL_BIT], headWord[7:0])) nextState = IDLE;
        end else if (selEmpty && (tmoCnt == TMO_LAST)) begin
          nextState = EEPW;
        end
      end
      EEPW: begin
        if (!tx_afull_i) begin
          eepNow    = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Tx write register and completion pulses, one cycle after the pop/EEP.
  always_ff @(posedge gclk) begin
    if (reset) begin
      tx_wr_o    <= 1'b0;
      tx_data_o  <= '0;
      pkt_done_o <= 1'b0;
      tmo_o      <= 1'b0;
    end else begin
      tx_wr_o    <= popNow || eepNow;
      pkt_done_o <= termPop || eepNow;
      tmo_o      <= eepNow;
      if (popNow)      tx_data_o <= headWord;
      else if (eepNow) tx_data_o <= EEP_WORD;
    end
  end

  // Grant register and round-robin pointer; the pointer moves past a line
  // only when its packet is finished.
  always_ff @(posedge gclk) begin
    if (reset) begin
      sel_line_o <= '0;
      selOneHot  <= '0;
      rrPtr      <= '0;
    end else begin
      if (takeGrant) begin
        sel_line_o <= grantIdx;
        selOneHot  <= grantVec;
      end
      if (termPop || eepNow) rrPtr <= nextPtr;
    end
  end

  // Stall timer: counts empty cycles on the granted line, ignores Tx backpressure.
  always_ff @(posedge gclk) begin
    if (reset || curState != XFER || popNow) tmoCnt <= '0;
    else if (selEmpty)                       tmoCnt <= (tmoCnt == TMO_LAST) ? '0 : tmoCnt + TW'(1);
  end

endmodule
